// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM states, AHB response codes,
// APB region map and the one-hot peripheral select decode.
package apb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_READ,
        ST_RENABLE,
        ST_WRITE,
        ST_WENABLE,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [31:0] REGION0_BASE  = 32'h8000_0000;
    localparam logic [31:0] REGION0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] REGION1_BASE  = 32'h8400_0000;
    localparam logic [31:0] REGION1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] REGION2_BASE  = 32'h8800_0000;
    localparam logic [31:0] REGION2_LIMIT = 32'h8BFF_FFFF;

    function automatic logic [2:0] apb_sel_decode(input logic [31:0] addr);
        logic [2:0] sel;
        sel = 3'b000;
        if (addr >= REGION0_BASE && addr <= REGION0_LIMIT) begin
            sel = 3'b001;
        end else if (addr >= REGION1_BASE && addr <= REGION1_LIMIT) begin
            sel = 3'b010;
        end else if (addr >= REGION2_BASE && addr <= REGION2_LIMIT) begin
            sel = 3'b100;
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_bridge_ctrl.sv
// APB-side sequencer of the AHB-to-APB bridge: APB3 SETUP/ACCESS phases, AHB wait
// states and the two-cycle AHB ERROR response on Pslverr.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no APB transfer; ready to accept an AHB address
// WWAIT    | write accepted, waiting one cycle for Hwdata
// READ     | APB read SETUP phase
// RENABLE  | APB read ACCESS phase (held while Pready=0)
// WRITE    | APB write SETUP phase
// WENABLE  | APB write ACCESS phase (held while Pready=0)
// ERR1     | first ERROR cycle, Hreadyout low
// ERR2     | second ERROR cycle, Hreadyout high; next address may be taken
module apb_bridge_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic              Hwrite,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [ADDR_W-1:0] Haddr1,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic              Pready,
    input  logic              Pslverr,
    output logic [2:0]        Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [1:0]        Hresp
);

    bridge_state_e     state_q, state_d, next_xfer;
    logic [2:0]        psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    // Where to go when a new AHB address phase may be accepted.
    assign next_xfer = !valid ? ST_IDLE : (Hwrite ? ST_WWAIT : ST_READ);

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        Hreadyout = 1'b0;
        Hresp     = HRESP_OKAY;

        case (state_q)
            ST_IDLE: begin
                state_d   = next_xfer;
                Hreadyout = 1'b1;
            end
            ST_WWAIT: state_d = ST_WRITE;
            ST_READ:  state_d = ST_RENABLE;
            ST_WRITE: state_d = ST_WENABLE;
            ST_RENABLE, ST_WENABLE: begin
                if (Pready) begin
                    state_d = Pslverr ? ST_ERR1 : next_xfer;
                end
                Hreadyout = Pready & ~Pslverr;
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
                Hresp   = HRESP_ERROR;
            end
            ST_ERR2: begin
                state_d   = next_xfer;
                Hreadyout = 1'b1;
                Hresp     = HRESP_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase

        // APB outputs are registered on the edge that enters the new state.
        case (state_d)
            ST_READ: begin
                paddr_d   = Haddr;
                pwrite_d  = 1'b0;
                psel_d    = apb_sel_decode(32'(Haddr));
                penable_d = 1'b0;
            end
            ST_WRITE: begin
                paddr_d   = Haddr1;
                pwdata_d  = Hwdata;
                pwrite_d  = 1'b1;
                psel_d    = apb_sel_decode(32'(Haddr1));
                penable_d = 1'b0;
            end
            ST_RENABLE, ST_WENABLE: penable_d = 1'b1;
            default: begin
                psel_d    = 3'b000;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_q   <= ST_IDLE;
            psel_q    <= 3'b000;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign Pselx   = psel_q;
    assign Penable = penable_q;
    assign Pwrite  = pwrite_q;
    assign Paddr   = paddr_q;
    assign Pwdata  = pwdata_q;

endmodule
